// File: rtl/picomips_core.sv
// picomips_core: two-stage (fetch/execute) picoMIPS core with valid/ready input and output ports.
// Define PICOMIPS_MUL_EN to turn op 011 from SUB into MULI (upper half of rs*imm).
module picomips_core #(
  parameter int N     = 8,
  parameter int PSIZE = 6,
  parameter int ISIZE = N + 8
) (
  input  logic             clk,
  input  logic             reset_n,
  output logic [PSIZE-1:0] imem_addr,
  input  logic [ISIZE-1:0] imem_data,
  output logic [N-1:0]     rom_addr,
  input  logic [N-1:0]     rom_data,
  input  logic [N-1:0]     in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [N-1:0]     out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef struct packed {
    logic [2:0]   op;
    logic [2:0]   rd;
    logic [1:0]   rs;
    logic [N-1:0] imm;
  } instr_t;

  typedef enum logic {LD_ADDR, LD_DATA} ld_state_t;

  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_ADDI = 3'b010;
  localparam logic [2:0] OP_ALU3 = 3'b011;
  localparam logic [2:0] OP_BEQ  = 3'b100;
  localparam logic [2:0] OP_IN   = 3'b101;
  localparam logic [2:0] OP_LDR  = 3'b110;
  localparam logic [2:0] OP_OUT  = 3'b111;

  logic [PSIZE-1:0]  pc, x_pc;
  logic              x_vld, held;
  instr_t            hold_q, ins;
  logic [7:0][N-1:0] regs;
  logic              z_q, c_q, z_d, c_d;
  ld_state_t         ld_q, ld_d;

  logic [N-1:0] rs_val, rd_val, wr_val;
  logic [N:0]   sum;
  logic         wr_en, arith;
  logic         op_in, op_ldr, op_out, out_go, taken, stall;

  // The sync ROM moves on to the next word while we stall, so the stalled
  // instruction is replayed from a local copy until the stall clears.
  assign ins    = held ? hold_q : instr_t'(imem_data);
  assign rs_val = regs[{1'b0, ins.rs}];
  assign rd_val = regs[ins.rd];

  assign op_in  = x_vld && (ins.op == OP_IN);
  assign op_ldr = x_vld && (ins.op == OP_LDR);
  assign op_out = x_vld && (ins.op == OP_OUT);
  assign taken  = x_vld && (ins.op == OP_BEQ) && z_q;
  assign out_go = op_out && (!out_valid || out_ready);
  assign stall  = (op_in && !in_valid) || (op_ldr && ld_q == LD_ADDR) || (op_out && !out_go);

  assign imem_addr = pc;
  assign in_ready  = op_in;
  assign rom_addr  = op_ldr ? rs_val + ins.imm : '0;

  always_comb begin
    wr_en  = 1'b0;
    wr_val = '0;
    arith  = 1'b0;
    sum    = '0;
    z_d    = z_q;
    c_d    = c_q;
    if (x_vld) begin
      case (ins.op)
        OP_ADD:  begin arith = 1'b1; sum = {1'b0, rs_val} + {1'b0, rd_val}; end
        OP_ADDI: begin arith = 1'b1; sum = {1'b0, rs_val} + {1'b0, ins.imm}; end
`ifdef PICOMIPS_MUL_EN
        OP_ALU3: begin
          wr_en  = 1'b1;
          wr_val = N'(({{N{1'b0}}, rs_val} * {{N{1'b0}}, ins.imm}) >> N);
          z_d    = (wr_val == '0);
          c_d    = 1'b0;
        end
`else
        OP_ALU3: begin arith = 1'b1; sum = {1'b0, rs_val} + {1'b0, ~rd_val} + (N+1)'(1); end
`endif
        OP_IN:   begin wr_en = in_valid; wr_val = in_data; end
        OP_LDR:  begin wr_en = (ld_q == LD_DATA); wr_val = rom_data; end
        default: ;
      endcase
    end
    if (arith) begin
      wr_en  = 1'b1;
      wr_val = sum[N-1:0];
      z_d    = (sum[N-1:0] == '0);
      c_d    = sum[N];
    end
  end

  always_comb begin
    ld_d = ld_q;
    case (ld_q)
      LD_ADDR: if (op_ldr) ld_d = LD_DATA;
      LD_DATA: ld_d = LD_ADDR;
      default: ld_d = LD_ADDR;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ld_q <= LD_ADDR;
    else          ld_q <= ld_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc        <= '0;
      x_pc      <= '0;
      x_vld     <= 1'b0;
      held      <= 1'b0;
      hold_q    <= '0;
      regs      <= '0;
      z_q       <= 1'b0;
      c_q       <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      if (stall) begin
        held   <= 1'b1;
        hold_q <= ins;
      end else begin
        held <= 1'b0;
        x_pc <= pc;
        if (taken) begin
          pc    <= x_pc + ins.imm[PSIZE-1:0];
          x_vld <= 1'b0;
        end else begin
          pc    <= pc + PSIZE'(1);
          x_vld <= 1'b1;
        end
      end
      if (wr_en && ins.rd != 3'd0) regs[ins.rd] <= wr_val;
      z_q <= z_d;
      c_q <= c_d;
      if (out_go) begin
        out_data  <= rs_val;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_picomips_core.sv
// Directed bench for picomips_core: sync program ROM and waveform ROM models, per-feature tasks.
module tb_picomips_core;
  logic       clk, reset_n;
  logic [5:0] imem_addr;
  logic [15:0] imem_data;
  logic [7:0] rom_addr, rom_data, in_data, out_data;
  logic       in_valid, in_ready, out_valid, out_ready;

  logic [15:0] prog [64];
  logic [7:0]  wrom [256];
  int errors = 0;
  int checks = 0;

  picomips_core #(.N(8), .PSIZE(6)) dut (
    .clk(clk), .reset_n(reset_n),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    imem_data <= prog[imem_addr];
    rom_data  <= wrom[rom_addr];
  end

  function automatic logic [15:0] enc(input logic [2:0] op, input logic [2:0] rd,
                                      input logic [1:0] rs, input logic [7:0] imm);
    return {op, rd, rs, imm};
  endfunction

  task automatic clear_prog();
    for (int i = 0; i < 64; i++) prog[i] = 16'h0000;
  endtask

  task automatic start();
    reset_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    clear_prog();
    prog[0] = enc(3'b101, 3'd3, 2'd0, 8'h00);
    reset_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (imem_addr !== 6'd0) begin errors++; $display("FAIL rst_pc: got %0h want 0", imem_addr); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL rst_out_data: got %0h want 0", out_data); end
    checks++; if (rom_addr !== 8'h00) begin errors++; $display("FAIL rst_rom_addr: got %0h want 0", rom_addr); end
    reset_n = 1'b1;
    step(1);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_first_x: got %b want 1", in_ready); end
  endtask

  task automatic test_add();
    clear_prog();
    prog[0] = enc(3'b010, 3'd1, 2'd0, 8'h05);
    prog[1] = enc(3'b001, 3'd1, 2'd1, 8'h00);
    start();
    step(1);
    checks++; if (dut.regs[1] !== 8'h00) begin errors++; $display("FAIL add_e1: got %0h want 0", dut.regs[1]); end
    checks++; if (imem_addr !== 6'd1) begin errors++; $display("FAIL add_pc1: got %0h want 1", imem_addr); end
    step(1);
    checks++; if (dut.regs[1] !== 8'h05) begin errors++; $display("FAIL add_e2: got %0h want 5", dut.regs[1]); end
    step(1);
    checks++; if (dut.regs[1] !== 8'h0A) begin errors++; $display("FAIL add_e3: got %0h want a", dut.regs[1]); end
  endtask

  task automatic test_arith();
    clear_prog();
`ifdef PICOMIPS_MUL_EN
    prog[0] = enc(3'b010, 3'd1, 2'd0, 8'h80);
    prog[1] = enc(3'b011, 3'd1, 2'd1, 8'h40);
    start();
    step(3);
    checks++; if (dut.regs[1] !== 8'h20) begin errors++; $display("FAIL muli: got %0h want 20", dut.regs[1]); end
    checks++; if (dut.c_q !== 1'b0) begin errors++; $display("FAIL muli_c: got %b want 0", dut.c_q); end
`else
    prog[0] = enc(3'b010, 3'd1, 2'd0, 8'h03);
    prog[1] = enc(3'b010, 3'd2, 2'd0, 8'h05);
    prog[2] = enc(3'b011, 3'd2, 2'd1, 8'h00);
    prog[3] = enc(3'b010, 3'd3, 2'd0, 8'hFF);
    prog[4] = enc(3'b010, 3'd3, 2'd3, 8'h01);
    prog[5] = enc(3'b010, 3'd0, 2'd1, 8'h09);
    start();
    step(4);
    checks++; if (dut.regs[2] !== 8'hFE) begin errors++; $display("FAIL sub_val: got %0h want fe", dut.regs[2]); end
    checks++; if (dut.c_q !== 1'b0) begin errors++; $display("FAIL sub_borrow: got %b want 0", dut.c_q); end
    step(2);
    checks++; if (dut.regs[3] !== 8'h00) begin errors++; $display("FAIL addi_wrap: got %0h want 0", dut.regs[3]); end
    checks++; if ({dut.z_q, dut.c_q} !== 2'b11) begin errors++; $display("FAIL addi_zc: got %b want 11", {dut.z_q, dut.c_q}); end
    step(1);
    checks++; if (dut.regs[0] !== 8'h00) begin errors++; $display("FAIL r0_write: got %0h want 0", dut.regs[0]); end
    checks++; if (dut.z_q !== 1'b0) begin errors++; $display("FAIL r0_z: got %b want 0", dut.z_q); end
`endif
  endtask

  task automatic test_branch();
    clear_prog();
    prog[0] = enc(3'b010, 3'd1, 2'd0, 8'h07);
    prog[2] = enc(3'b010, 3'd2, 2'd0, 8'h00);
    prog[3] = enc(3'b100, 3'd0, 2'd0, 8'hFE);
    prog[4] = enc(3'b010, 3'd6, 2'd0, 8'h55);
    start();
    step(4);
    checks++; if (imem_addr !== 6'd4) begin errors++; $display("FAIL br_pc4: got %0h want 4", imem_addr); end
    checks++; if (dut.z_q !== 1'b1) begin errors++; $display("FAIL br_z: got %b want 1", dut.z_q); end
    step(1);
    checks++; if (imem_addr !== 6'd1) begin errors++; $display("FAIL br_target: got %0h want 1", imem_addr); end
    checks++; if (dut.x_vld !== 1'b0) begin errors++; $display("FAIL br_bubble: got %b want 0", dut.x_vld); end
    step(1);
    checks++; if (imem_addr !== 6'd2) begin errors++; $display("FAIL br_resume: got %0h want 2", imem_addr); end
    checks++; if (dut.x_vld !== 1'b1) begin errors++; $display("FAIL br_one_bubble: got %b want 1", dut.x_vld); end
    step(8);
    checks++; if (dut.regs[6] !== 8'h00) begin errors++; $display("FAIL br_squash: got %0h want 0", dut.regs[6]); end
    checks++; if (dut.regs[1] !== 8'h07) begin errors++; $display("FAIL br_r1: got %0h want 7", dut.regs[1]); end
  endtask

  task automatic test_in();
    clear_prog();
    prog[0] = enc(3'b101, 3'd3, 2'd0, 8'h00);
    prog[1] = enc(3'b010, 3'd1, 2'd0, 8'h01);
    start();
    for (int i = 0; i < 4; i++) begin
      step(1);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL in_wait_rdy%0d: got %b want 1", i, in_ready); end
      checks++; if (imem_addr !== 6'd1) begin errors++; $display("FAIL in_wait_pc%0d: got %0h want 1", i, imem_addr); end
    end
    in_valid = 1'b1; in_data = 8'hA5;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL in_xfer_rdy: got %b want 1", in_ready); end
    step(1);
    in_valid = 1'b0;
    checks++; if (dut.regs[3] !== 8'hA5) begin errors++; $display("FAIL in_r3: got %0h want a5", dut.regs[3]); end
    checks++; if (imem_addr !== 6'd2) begin errors++; $display("FAIL in_pc: got %0h want 2", imem_addr); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL in_done_rdy: got %b want 0", in_ready); end
    step(1);
    checks++; if (dut.regs[1] !== 8'h01) begin errors++; $display("FAIL in_next: got %0h want 1", dut.regs[1]); end
  endtask

  task automatic test_ldr();
    clear_prog();
    prog[0] = enc(3'b010, 3'd1, 2'd0, 8'h10);
    prog[1] = enc(3'b110, 3'd4, 2'd1, 8'h03);
    prog[2] = enc(3'b010, 3'd5, 2'd0, 8'h01);
    start();
    step(2);
    checks++; if (rom_addr !== 8'h13) begin errors++; $display("FAIL ldr_addr1: got %0h want 13", rom_addr); end
    checks++; if (imem_addr !== 6'd2) begin errors++; $display("FAIL ldr_pc1: got %0h want 2", imem_addr); end
    step(1);
    checks++; if (rom_addr !== 8'h13) begin errors++; $display("FAIL ldr_addr2: got %0h want 13", rom_addr); end
    checks++; if (imem_addr !== 6'd2) begin errors++; $display("FAIL ldr_pc2: got %0h want 2", imem_addr); end
    checks++; if (dut.regs[4] !== 8'h00) begin errors++; $display("FAIL ldr_early: got %0h want 0", dut.regs[4]); end
    step(1);
    checks++; if (dut.regs[4] !== 8'h7E) begin errors++; $display("FAIL ldr_r4: got %0h want 7e", dut.regs[4]); end
    checks++; if (imem_addr !== 6'd3) begin errors++; $display("FAIL ldr_pc3: got %0h want 3", imem_addr); end
    checks++; if (rom_addr !== 8'h00) begin errors++; $display("FAIL ldr_idle: got %0h want 0", rom_addr); end
    step(1);
    checks++; if (dut.regs[5] !== 8'h01) begin errors++; $display("FAIL ldr_next: got %0h want 1", dut.regs[5]); end
  endtask

  task automatic test_back_to_back();
    clear_prog();
    prog[0] = enc(3'b010, 3'd1, 2'd0, 8'h11);
    prog[1] = enc(3'b010, 3'd2, 2'd0, 8'h22);
    prog[2] = enc(3'b111, 3'd0, 2'd1, 8'h00);
    prog[3] = enc(3'b111, 3'd0, 2'd2, 8'h00);
    start();
    step(3);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL out_pre: got %b want 0", out_valid); end
    step(1);
    checks++; if (out_data !== 8'h11) begin errors++; $display("FAIL out_first: got %0h want 11", out_data); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL out_first_v: got %b want 1", out_valid); end
    for (int i = 0; i < 2; i++) begin
      step(1);
      checks++; if (out_data !== 8'h11) begin errors++; $display("FAIL out_hold%0d: got %0h want 11", i, out_data); end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL out_hold_v%0d: got %b want 1", i, out_valid); end
      checks++; if (imem_addr !== 6'd4) begin errors++; $display("FAIL out_stall_pc%0d: got %0h want 4", i, imem_addr); end
    end
    out_ready = 1'b1;
    step(1);
    checks++; if (out_data !== 8'h22) begin errors++; $display("FAIL out_second: got %0h want 22", out_data); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL out_second_v: got %b want 1", out_valid); end
    checks++; if (imem_addr !== 6'd5) begin errors++; $display("FAIL out_pc: got %0h want 5", imem_addr); end
    step(1);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL out_drain: got %b want 0", out_valid); end
    checks++; if (out_data !== 8'h22) begin errors++; $display("FAIL out_keep: got %0h want 22", out_data); end
  endtask

  task automatic test_reset_mid_ldr();
    clear_prog();
    prog[0] = enc(3'b010, 3'd1, 2'd0, 8'h10);
    prog[1] = enc(3'b111, 3'd0, 2'd1, 8'h00);
    prog[2] = enc(3'b110, 3'd4, 2'd1, 8'h03);
    start();
    step(3);
    checks++; if (rom_addr !== 8'h13) begin errors++; $display("FAIL mid_addr: got %0h want 13", rom_addr); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_out_v: got %b want 1", out_valid); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (rom_addr !== 8'h00) begin errors++; $display("FAIL mid_rst_rom: got %0h want 0", rom_addr); end
    checks++; if (imem_addr !== 6'd0) begin errors++; $display("FAIL mid_rst_pc: got %0h want 0", imem_addr); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_out_v: got %b want 0", out_valid); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL mid_rst_out_d: got %0h want 0", out_data); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_in_rdy: got %b want 0", in_ready); end
    checks++; if (dut.regs[1] !== 8'h00) begin errors++; $display("FAIL mid_rst_r1: got %0h want 0", dut.regs[1]); end
    @(negedge clk) reset_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) wrom[i] = 8'(i) ^ 8'h5A;
    wrom[8'h13] = 8'h7E;
    reset_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    test_reset();
    test_add();
    test_arith();
    test_branch();
    test_in();
    test_ldr();
    test_back_to_back();
    test_reset_mid_ldr();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
